// File: rtl/wb_arbiter_pkg.sv
// Shared register-bank constants and the writeback request type used by the
// writeback arbiter and its load FIFO.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the result producers, the arbiter and the register bank.
// slave = arbiter side, master = producer/consumer side.
interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    import wb_arbiter_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // A transfer happens on a cycle where valid && ready; ready never depends
    // on valid, and a producer holds rd/data stable while valid is high.
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  wr_reg;
    logic [REG_ADDR_W-1:0] wr_rd;
    logic [XLEN-1:0]       wr_data;
    logic [NUM_REGS-1:0]   pending_mask;
    logic [CNT_W-1:0]      fifo_count;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready, wr_reg, wr_rd, wr_data, pending_mask, fifo_count
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready, wr_reg, wr_rd, wr_data, pending_mask, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous load-result FIFO with a per-slot valid/rd view so the arbiter
// can build the pending-destination mask from the queued entries.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  wb_req_t                          din,
    output wb_req_t                          dout,
    output logic                             full,
    output logic                             empty,
    output logic [CNT_W-1:0]                 count,
    output logic [DEPTH-1:0]                 entry_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: slot validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] off;
        assign off          = PTR_W'(g) - rd_ptr;
        assign entry_vld[g] = ({1'b0, off} < count);
        assign entry_rd[g]  = mem[g].rd;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU first, then queued loads, then load bypass.
// Optional forced drain of starved loads with WB_STARVE_GUARD_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef WB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = 8
`endif
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_req_t                          head;
    wb_req_t                          ld_req;
    logic                             full;
    logic                             empty;
    logic [CNT_W-1:0]                 count;
    logic [DEPTH-1:0]                 entry_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
    logic                             alu_win;
    logic                             ld_live;
    logic                             push;
    logic                             pop;
    logic                             bypass;
    logic [NUM_REGS-1:0]              mask;

    assign ld_req   = '{rd: bus.ld_rd, data: bus.ld_data};
    assign bus.ld_ready = !full;

    // rd==0 transfers are still handshaken but never reach the bank.
    assign alu_win = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
    assign ld_live = bus.ld_valid && bus.ld_ready && (bus.ld_rd != '0);
    assign pop     = !alu_win && !empty;
    assign bypass  = !alu_win && empty && ld_live;
    assign push    = ld_live && !bypass;

`ifdef WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_cnt;
    logic            force_drain;

    // Withholding alu_ready for one cycle lets the head pop through case 2.
    assign force_drain   = !empty && (starve_cnt == SC_W'(STARVE_LIMIT));
    assign bus.alu_ready = !force_drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                starve_cnt <= '0;
        else if (pop || empty)  starve_cnt <= '0;
        else if (alu_win)       starve_cnt <= starve_cnt + SC_W'(1);
    end
`else
    assign bus.alu_ready = 1'b1;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (ld_req),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .entry_vld (entry_vld),
        .entry_rd  (entry_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_reg  <= 1'b0;
            bus.wr_rd   <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_reg <= alu_win || pop || bypass;
            if (alu_win) begin
                bus.wr_rd   <= bus.alu_rd;
                bus.wr_data <= bus.alu_data;
            end else if (pop) begin
                bus.wr_rd   <= head.rd;
                bus.wr_data <= head.data;
            end else if (bypass) begin
                bus.wr_rd   <= ld_req.rd;
                bus.wr_data <= ld_req.data;
            end
        end
    end

    // Built from FIFO state only, so it follows a push/pop one cycle later;
    // the entry already in the output register has left the FIFO.
    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) mask = mask | rd_onehot(entry_rd[i]);
        end
    end

    assign bus.pending_mask = mask;
    assign bus.fifo_count   = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=4); the starve sequence follows
// WB_STARVE_GUARD_EN the same way the RTL does.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.ld_valid = v;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
    endtask

    initial begin
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);

        // reset state
        #2 rst = 1'b1;
        #2;
        chk("rst_wr_reg", bus.wr_reg, 0);
        chk("rst_wr_rd", bus.wr_rd, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_pending", bus.pending_mask, 0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_alu_ready", bus.alu_ready, 1);
        tick();
        rst = 1'b0;

        // ALU only
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        chk("alu_wr_reg", bus.wr_reg, 1);
        chk("alu_wr_rd", bus.wr_rd, 5);
        chk("alu_wr_data", bus.wr_data, 32'hDEADBEEF);
        chk("alu_count", bus.fifo_count, 0);
        tick();
        chk("idle_wr_reg", bus.wr_reg, 0);
        chk("idle_wr_rd_hold", bus.wr_rd, 5);
        chk("idle_wr_data_hold", bus.wr_data, 32'hDEADBEEF);

        // collision
        drive_alu(1'b1, 5'd3, 32'h11);
        drive_ld(1'b1, 5'd7, 32'h22);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        chk("col1_wr_rd", bus.wr_rd, 3);
        chk("col1_wr_data", bus.wr_data, 32'h11);
        chk("col1_pending", bus.pending_mask, 32'h80);
        chk("col1_count", bus.fifo_count, 1);
        tick();
        chk("col2_wr_reg", bus.wr_reg, 1);
        chk("col2_wr_rd", bus.wr_rd, 7);
        chk("col2_wr_data", bus.wr_data, 32'h22);
        chk("col2_pending", bus.pending_mask, 0);
        chk("col2_count", bus.fifo_count, 0);

        // bypass on empty FIFO
        drive_ld(1'b1, 5'd9, 32'h33);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        chk("byp_wr_rd", bus.wr_rd, 9);
        chk("byp_wr_data", bus.wr_data, 32'h33);
        chk("byp_count", bus.fifo_count, 0);
        chk("byp_pending", bus.pending_mask, 0);

        // fill under ALU pressure, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            drive_alu(1'b1, 5'd1, 32'h100 + i);
            drive_ld(1'b1, 5'(10 + i), 32'hA0 + i);
            chk("fill_ld_ready", bus.ld_ready, 1);
            tick();
        end
        chk("full_ld_ready", bus.ld_ready, 0);
        chk("full_count", bus.fifo_count, DEPTH);
        chk("full_pending", bus.pending_mask, 32'h3C00);
        chk("full_wr_rd", bus.wr_rd, 1);
        chk("full_wr_data", bus.wr_data, 32'h103);
        drive_ld(1'b1, 5'd14, 32'hEE);
        tick();
        chk("full_hold_count", bus.fifo_count, DEPTH);
        chk("full_hold_pending", bus.pending_mask, 32'h3C00);
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("drain_wr_reg", bus.wr_reg, 1);
            chk("drain_wr_rd", bus.wr_rd, 10 + i);
            chk("drain_wr_data", bus.wr_data, 32'hA0 + i);
            chk("drain_count", bus.fifo_count, 3 - i);
            if (i == 0) chk("drain_pending", bus.pending_mask, 32'h3800);
        end

        // x0 discard, then ALU x0 alongside a live load
        drive_alu(1'b1, 5'd0, 32'hFF);
        drive_ld(1'b1, 5'd0, 32'hEE);
        tick();
        chk("x0_wr_reg", bus.wr_reg, 0);
        chk("x0_count", bus.fifo_count, 0);
        chk("x0_pending", bus.pending_mask, 0);
        drive_ld(1'b1, 5'd4, 32'h44);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        chk("x0alu_wr_reg", bus.wr_reg, 1);
        chk("x0alu_wr_rd", bus.wr_rd, 4);
        chk("x0alu_wr_data", bus.wr_data, 32'h44);
        chk("x0alu_count", bus.fifo_count, 0);

        // async reset with three loads queued
        for (int i = 0; i < 3; i++) begin
            drive_alu(1'b1, 5'd2, 32'h200 + i);
            drive_ld(1'b1, 5'(20 + i), 32'hC0 + i);
            tick();
        end
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        chk("pre_rst_count", bus.fifo_count, 3);
        chk("pre_rst_pending", bus.pending_mask, 32'h700000);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_wr_reg", bus.wr_reg, 0);
        chk("mid_rst_wr_rd", bus.wr_rd, 0);
        chk("mid_rst_count", bus.fifo_count, 0);
        chk("mid_rst_pending", bus.pending_mask, 0);
        chk("mid_rst_ld_ready", bus.ld_ready, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_wr_reg", bus.wr_reg, 0);
            chk("post_rst_count", bus.fifo_count, 0);
        end

        // one queued load under continuous ALU traffic
        drive_alu(1'b1, 5'd1, 32'h300);
        drive_ld(1'b1, 5'd15, 32'h55);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        chk("stv_count", bus.fifo_count, 1);
        chk("stv_pending", bus.pending_mask, 32'h8000);
`ifdef WB_STARVE_GUARD_EN
        for (int i = 0; i < 8; i++) begin
            chk("stv_alu_ready_hi", bus.alu_ready, 1);
            tick();
        end
        chk("stv_alu_ready_lo", bus.alu_ready, 0);
        chk("stv_lo_count", bus.fifo_count, 1);
        tick();
        chk("stv_drain_wr_rd", bus.wr_rd, 15);
        chk("stv_drain_wr_data", bus.wr_data, 32'h55);
        chk("stv_drain_count", bus.fifo_count, 0);
        chk("stv_alu_ready_back", bus.alu_ready, 1);
        drive_alu(1'b0, 5'd0, 32'h0);
`else
        for (int i = 0; i < 9; i++) begin
            chk("stv_alu_ready", bus.alu_ready, 1);
            tick();
        end
        chk("stv_starved_count", bus.fifo_count, 1);
        chk("stv_starved_wr_rd", bus.wr_rd, 1);
        drive_alu(1'b0, 5'd0, 32'h0);
        tick();
        chk("stv_drain_wr_rd", bus.wr_rd, 15);
        chk("stv_drain_wr_data", bus.wr_data, 32'h55);
        chk("stv_drain_count", bus.fifo_count, 0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
